// File: rtl/cpu_bus_dma.sv
// CPU-side bus decoder/mux with internal RAM, open-bus latch and OAM DMA.
//
// Decodes the (CPU or DMA) bus address into chip selects for internal RAM,
// PPU, APU/IO, cartridge PRG-RAM and PRG-ROM, and returns read data to the
// CPU one cycle after the address. A write to DMA_REG halts the CPU and
// copies 256 bytes from page $XX00 to OAM_PORT.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   cpu_rw/addr/data_i       CPU request (rw: 1 = read, 0 = write)
//   cpu_data_o               read data to CPU (one-cycle latency)
//   cpu_rdy                  0 while the DMA engine owns the bus
//   bus_addr/rw/data_w       muxed request to peripherals
//   ppu_cs/apu_cs/prgram_cs/rom_cs   combinational chip selects
//   ppu/apu/cart_data_i      peripheral read data
//   dma_active               DMA FSM not idle
module cpu_bus_dma #(
  parameter int unsigned RAM_AW     = 11,
  parameter logic [15:0] DMA_REG    = 16'h4014,
  parameter logic [15:0] OAM_PORT   = 16'h2004,
  parameter bit          PRG_RAM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic        bus_rw,
  output logic [7:0]  bus_data_w,
  output logic        ppu_cs,
  output logic        apu_cs,
  output logic        prgram_cs,
  output logic        rom_cs,
  input  logic [7:0]  ppu_data_i,
  input  logic [7:0]  apu_data_i,
  input  logic [7:0]  cart_data_i,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  cnt;
  logic        parity;

  logic [7:0]  mem [2**RAM_AW];
  logic [7:0]  ram_q;
  logic [7:0]  ppu_q;
  logic [7:0]  ob_q;
  logic        ram_rd_q, cart_rd_q, apu_rd_q, ppu_rd_q;
  logic        ram_sel;
  logic [7:0]  rd_mux;

  // Bus ownership: CPU in IDLE, DMA FSM otherwise.
  always_comb begin
    bus_addr   = cpu_addr;
    bus_rw     = cpu_rw;
    bus_data_w = cpu_data_i;
    case (state)
      S_HALT, S_ALIGN: bus_rw = 1'b1;
      S_READ: begin
        bus_addr = {page, cnt};
        bus_rw   = 1'b1;
      end
      S_WRITE: begin
        bus_addr   = OAM_PORT;
        bus_rw     = 1'b0;
        bus_data_w = rd_mux;
      end
      default: ;
    endcase
  end

  always_comb begin
    ram_sel   = (bus_addr[15:13] == 3'b000);
    ppu_cs    = (bus_addr[15:13] == 3'b001);
    apu_cs    = (bus_addr[15:5] == 11'h200) && (bus_addr != DMA_REG);
    prgram_cs = PRG_RAM_EN && (bus_addr[15:13] == 3'b011);
    rom_cs    = bus_addr[15];
  end

  // Return mux driven by last cycle's read selects; nothing selected -> open bus.
  always_comb begin
    if (ram_rd_q)       rd_mux = ram_q;
    else if (cart_rd_q) rd_mux = cart_data_i;
    else if (apu_rd_q)  rd_mux = apu_data_i;
    else if (ppu_rd_q)  rd_mux = ppu_q;
    else                rd_mux = ob_q;
    cpu_data_o = rd_mux;
  end

  always_ff @(posedge clk) begin
    if (ram_sel && !bus_rw) mem[bus_addr[RAM_AW-1:0]] <= bus_data_w;
    ram_q <= mem[bus_addr[RAM_AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity    <= 1'b0;
      ram_rd_q  <= 1'b0;
      cart_rd_q <= 1'b0;
      apu_rd_q  <= 1'b0;
      ppu_rd_q  <= 1'b0;
      ppu_q     <= '0;
      ob_q      <= '0;
    end else begin
      parity    <= ~parity;
      ram_rd_q  <= ram_sel & bus_rw;
      cart_rd_q <= (prgram_cs | rom_cs) & bus_rw;
      apu_rd_q  <= apu_cs & bus_rw;
      ppu_rd_q  <= ppu_cs & bus_rw;
      ppu_q     <= ppu_data_i;
      // A write in the same cycle as a returning read is the newer bus value.
      if (!bus_rw)
        ob_q <= bus_data_w;
      else if (ram_rd_q | cart_rd_q | apu_rd_q | ppu_rd_q)
        ob_q <= rd_mux;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      page       <= '0;
      cnt        <= '0;
      cpu_rdy    <= 1'b1;
      dma_active <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!cpu_rw && cpu_addr == DMA_REG) begin
            page       <= cpu_data_i;
            cnt        <= '0;
            state      <= S_HALT;
            cpu_rdy    <= 1'b0;
            dma_active <= 1'b1;
          end
        end
        S_HALT:  state <= parity ? S_READ : S_ALIGN;
        S_ALIGN: state <= S_READ;
        S_READ:  state <= S_WRITE;
        S_WRITE: begin
          cnt <= cnt + 8'd1;
          if (cnt == 8'hFF) begin
            state      <= S_IDLE;
            cpu_rdy    <= 1'b1;
            dma_active <= 1'b0;
          end else begin
            state <= S_READ;
          end
        end
        default: begin
          state      <= S_IDLE;
          cpu_rdy    <= 1'b1;
          dma_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_bus_dma.sv
module tb_cpu_bus_dma;

  localparam logic [15:0] OAM = 16'h2004;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = 16'h5000;
  logic [7:0]  cpu_data_i = 8'h00;
  logic [7:0]  cpu_data_o;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_data_w;
  logic        ppu_cs, apu_cs, prgram_cs, rom_cs;
  logic [7:0]  ppu_data_i = 8'h00;
  logic [7:0]  apu_data_i = 8'h00;
  logic [7:0]  cart_data_i = 8'h00;
  logic        dma_active;

  cpu_bus_dma #(
    .RAM_AW(11),
    .DMA_REG(16'h4014),
    .OAM_PORT(16'h2004),
    .PRG_RAM_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_rdy(cpu_rdy),
    .bus_addr(bus_addr), .bus_rw(bus_rw), .bus_data_w(bus_data_w),
    .ppu_cs(ppu_cs), .apu_cs(apu_cs), .prgram_cs(prgram_cs), .rom_cs(rom_cs),
    .ppu_data_i(ppu_data_i), .apu_data_i(apu_data_i), .cart_data_i(cart_data_i),
    .dma_active(dma_active)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; bit 0 is the expected frame parity.
  int unsigned edges;
  always @(posedge clk or posedge rst)
    if (rst) edges <= 0;
    else     edges <= edges + 1;

  typedef enum {K_NONE, K_RAM, K_PPU, K_APU, K_CART} kind_e;

  int          total = 0;
  int          bad = 0;
  logic [7:0]  ram_m [2048];
  logic [7:0]  ob_m = 8'h00;
  kind_e       prev_k = K_NONE;
  logic [7:0]  prev_ram = 8'h00;
  logic [7:0]  prev_ppu = 8'h00;
  logic [7:0]  obs_d;
  logic        obs_apu;
  logic [7:0]  wq [$];
  int unsigned low;

  function automatic kind_e kind_of(input logic [15:0] a);
    if (a <= 16'h1FFF)                      return K_RAM;
    if (a <= 16'h3FFF)                      return K_PPU;
    if (a >= 16'h4000 && a <= 16'h401F && a != 16'h4014) return K_APU;
    if (a >= 16'h6000)                      return K_CART;
    return K_NONE;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One CPU bus cycle: drive, check last cycle's return data and this cycle's
  // decode, advance the reference model, then step to the next cycle.
  task automatic access(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                        input logic [7:0] pd);
    logic [7:0] exp;
    cpu_rw = rw; cpu_addr = a; cpu_data_i = wd;
    ppu_data_i = pd; apu_data_i = pd ^ 8'h3C; cart_data_i = pd ^ 8'hC3;
    case (prev_k)
      K_RAM:   exp = prev_ram;
      K_PPU:   exp = prev_ppu;
      K_APU:   exp = apu_data_i;
      K_CART:  exp = cart_data_i;
      default: exp = ob_m;
    endcase
    #2;
    obs_d = cpu_data_o;
    obs_apu = apu_cs;
    chk("rdata", 16'(cpu_data_o), 16'(exp));
    chk("ppu_cs", 16'(ppu_cs), 16'(a >= 16'h2000 && a <= 16'h3FFF));
    chk("apu_cs", 16'(apu_cs), 16'(a >= 16'h4000 && a <= 16'h401F && a != 16'h4014));
    chk("prgram_cs", 16'(prgram_cs), 16'(a >= 16'h6000 && a <= 16'h7FFF));
    chk("rom_cs", 16'(rom_cs), 16'(a >= 16'h8000));
    chk("rdy", 16'(cpu_rdy), 16'd1);
    if (!rw) ob_m = wd;
    else if (prev_k != K_NONE) ob_m = exp;
    prev_k   = rw ? kind_of(a) : K_NONE;
    prev_ram = ram_m[a[10:0]];
    prev_ppu = pd;
    if (!rw && kind_of(a) == K_RAM) ram_m[a[10:0]] = wd;
    @(posedge clk); #1;
  endtask

  task automatic dma_start(input logic want_par);
    if (edges[0] == want_par) access(1'b1, 16'h5000, 8'h00, 8'($urandom));
    access(1'b0, 16'h4014, 8'h02, 8'($urandom));
  endtask

  // Watch the halted bus; stops in the first cycle cpu_rdy is back, or once
  // abort_at OAM writes were seen, or after a cycle budget.
  task automatic dma_watch(input int unsigned abort_at);
    low = 0;
    wq.delete();
    cpu_rw = 1'b1; cpu_addr = 16'h5000; cpu_data_i = 8'h00;
    for (int c = 0; c < 700; c++) begin
      #2;
      if (cpu_rdy === 1'b1) break;
      low++;
      if (bus_rw === 1'b0 && bus_addr === OAM) wq.push_back(bus_data_w);
      if (abort_at != 0 && wq.size() == abort_at) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic dma_check(input string tag, input int unsigned exp_low);
    chk({tag, "_low"}, 16'(low), 16'(exp_low));
    chk({tag, "_nwr"}, 16'(wq.size()), 16'd256);
    for (int i = 0; i < 256 && i < wq.size(); i++)
      chk({tag, "_byte"}, 16'(wq[i]), 16'(8'(i) ^ 8'hA5));
    chk({tag, "_ob"}, 16'(cpu_data_o), 16'h005A);
    chk({tag, "_act"}, 16'(dma_active), 16'd0);
    @(posedge clk); #1;
    ob_m = 8'h5A;
    prev_k = K_NONE;
  endtask

  initial begin
    logic [15:0] a;
    logic        rw;
    int unsigned nwr;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy", 16'(cpu_rdy), 16'd1);
    chk("rst_act", 16'(dma_active), 16'd0);
    chk("rst_data", 16'(cpu_data_o), 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 2048; i++) access(1'b0, 16'(i), 8'($urandom), 8'($urandom));

    // RAM write then mirrored read
    access(1'b0, 16'h0123, 8'h5A, 8'($urandom));
    access(1'b1, 16'h1923, 8'h00, 8'($urandom));
    access(1'b1, 16'h5000, 8'h00, 8'($urandom));
    chk("t1_ram", 16'(obs_d), 16'h005A);
    // open bus keeps the last returned value, then the last written one
    access(1'b0, 16'h5000, 8'h77, 8'($urandom));
    chk("t2_ob", 16'(obs_d), 16'h005A);
    access(1'b1, 16'h5000, 8'h00, 8'($urandom));
    access(1'b1, 16'h5000, 8'h00, 8'($urandom));
    chk("t2_wr", 16'(obs_d), 16'h0077);
    // APU read path
    access(1'b1, 16'h4016, 8'h00, 8'($urandom));
    chk("t3_apucs", 16'(obs_apu), 16'd1);
    access(1'b1, 16'h5000, 8'h00, 8'h41 ^ 8'h3C);
    chk("t3_apu", 16'(obs_d), 16'h0041);
    access(1'b1, 16'h4014, 8'h00, 8'($urandom));

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'($urandom_range(0, 16'h1FFF));
        1:       a = 16'h2000 + 16'($urandom_range(0, 16'h1FFF));
        2:       a = 16'h4000 + 16'($urandom_range(0, 31));
        3:       a = 16'h4020 + 16'($urandom_range(0, 16'h1FDF));
        4:       a = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
        default: a = 16'h8000 + 16'($urandom_range(0, 16'h7FFF));
      endcase
      rw = ($urandom_range(0, 2) != 0);
      if (!rw && a == 16'h4014) rw = 1'b1;
      access(rw, a, 8'($urandom), 8'($urandom));
    end

    for (int i = 0; i < 256; i++)
      access(1'b0, 16'h0200 + 16'(i), 8'(i) ^ 8'hA5, 8'($urandom));

    dma_start(1'b1);
    chk("t3_dma_apucs", 16'(obs_apu), 16'd0);
    dma_watch(0);
    dma_check("dma_p1", 513);
    for (int i = 0; i < 4; i++) access(1'b1, 16'($urandom_range(0, 16'h1FFF)), 8'h00, 8'($urandom));

    dma_start(1'b0);
    dma_watch(0);
    dma_check("dma_p0", 514);
    access(1'b1, 16'h4016, 8'h00, 8'($urandom));
    access(1'b1, 16'h0205, 8'h00, 8'($urandom));

    // reset while the engine is mid-copy
    dma_start(1'b1);
    dma_watch(100);
    chk("rst_mid_nwr", 16'(wq.size()), 16'd100);
    rst = 1'b1;
    #1;
    chk("rst_mid_rdy", 16'(cpu_rdy), 16'd1);
    chk("rst_mid_act", 16'(dma_active), 16'd0);
    chk("rst_mid_data", 16'(cpu_data_o), 16'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    nwr = 0;
    for (int c = 0; c < 20; c++) begin
      #2;
      if (bus_rw === 1'b0 && bus_addr === OAM) nwr++;
      @(posedge clk); #1;
    end
    chk("rst_mid_nowr", 16'(nwr), 16'd0);
    chk("rst_mid_rdy2", 16'(cpu_rdy), 16'd1);
    ob_m = 8'h00;
    prev_k = K_NONE;
    access(1'b1, 16'h0210, 8'h00, 8'($urandom));
    access(1'b1, 16'h8123, 8'h00, 8'($urandom));
    access(1'b1, 16'h5000, 8'h00, 8'($urandom));
    access(1'b1, 16'h5000, 8'h00, 8'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
